issue_scheduler: RTL and testbench

Parametrised issue arbiter and common-data-bus (CDB) slot scheduler for the out-of-order back end. It sits between the per-unit issue queues and the execution units. Each cycle it grants at most one ready queue so that every result lands on the single CDB in a cycle nobody else has claimed. It generalises the fixed four-unit issue logic to N units with per-unit latency and per-unit pipelined/non-pipelined mode. It also tags each reserved CDB slot with the owning unit ID.

---
 rtl/issue_scheduler.sv | 113 +++++++++++
 tb/tb_issue_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/issue_scheduler.sv
// Issue arbiter and CDB slot scheduler: grants at most one ready queue per cycle
// so that every result lands on the single common data bus in an unclaimed cycle.
module issue_scheduler #(
  parameter int                  NUM_FU       = 4,
  parameter int                  RES_DEPTH    = 8,
  parameter logic [4*NUM_FU-1:0] FU_LAT       = 16'h1631,
  parameter                      NONPIPE_MASK = 4'b0100,
  parameter int                  IDW          = $clog2(NUM_FU)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_FU-1:0]    ready,
  input  logic [NUM_FU-1:0]    fu_busy_ext,
  input  logic                 issue_hold,
  output logic [NUM_FU-1:0]    issue,
  output logic                 cdb_expect,
  output logic [IDW-1:0]       cdb_fu_id,
  output logic [RES_DEPTH-1:0] resv_vec
);

  localparam int                CW      = $clog2(RES_DEPTH);
  localparam logic [NUM_FU-1:0] NP_MASK = NONPIPE_MASK[NUM_FU-1:0];

  function automatic int lat_of(input int i);
    return int'(FU_LAT[4*i+:4]);
  endfunction

  if ($bits(NONPIPE_MASK) > NUM_FU) begin : g_bad_mask
    $error("issue_scheduler: NONPIPE_MASK wider than NUM_FU");
  end

  logic [RES_DEPTH-1:0]          resv_q, resv_d;
  logic [RES_DEPTH-1:0][IDW-1:0] tag_q, tag_d;
  logic [NUM_FU-1:0][CW-1:0]     busy_cnt_q, busy_cnt_d;
  logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;

  logic [NUM_FU-1:0] elig;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_unit
    localparam int L = int'(FU_LAT[4*i+:4]);
    localparam logic [CW-1:0] LIDX = CW'((L < RES_DEPTH) ? L : 0);
    if (L == 0 || L >= RES_DEPTH) begin : g_bad_lat
      $error("issue_scheduler: latency of unit %0d out of range", i);
    end
    // rst gates eligibility so no grant leaks out while reset is held
    assign elig[i] = ready[i] & ~fu_busy_ext[i] & ~resv_q[LIDX] & ~issue_hold & ~rst &
                     (~NP_MASK[i] | (busy_cnt_q[i] == '0));
  end

  int             max_lat;
  int             n_tie;
  logic           found;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  logic [CW-1:0]  slot;

  // Longest latency wins; equal latencies rotate starting after rr_ptr.
  always_comb begin
    max_lat = 0;
    n_tie   = 0;
    found   = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    issue   = '0;
    for (int i = 0; i < NUM_FU; i++)
      if (elig[i] && lat_of(i) > max_lat) max_lat = lat_of(i);
    for (int i = 0; i < NUM_FU; i++)
      if (elig[i] && lat_of(i) == max_lat) n_tie = n_tie + 1;
    for (int k = 1; k <= NUM_FU; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_FU);
      if (!found && elig[idx] && lat_of(int'(idx)) == max_lat) begin
        found      = 1'b1;
        gnt_id     = idx;
        issue[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    resv_d   = resv_q >> 1;
    tag_d    = '0;
    rr_ptr_d = rr_ptr_q;
    slot     = CW'(lat_of(int'(gnt_id)) - 1);
    for (int k = 0; k < RES_DEPTH - 1; k++) tag_d[k] = tag_q[k+1];
    for (int i = 0; i < NUM_FU; i++)
      busy_cnt_d[i] = (busy_cnt_q[i] != '0) ? busy_cnt_q[i] - 1'b1 : '0;
    if (found) begin
      resv_d[slot] = 1'b1;
      tag_d[slot]  = gnt_id;
      if (n_tie > 1) rr_ptr_d = gnt_id;
      if (NP_MASK[gnt_id]) busy_cnt_d[gnt_id] = slot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_q     <= '0;
      tag_q      <= '0;
      busy_cnt_q <= '0;
      rr_ptr_q   <= IDW'(NUM_FU - 1);
    end else begin
      resv_q     <= resv_d;
      tag_q      <= tag_d;
      busy_cnt_q <= busy_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign cdb_expect = resv_q[0];
  assign cdb_fu_id  = resv_q[0] ? tag_q[0] : '0;
  assign resv_vec   = resv_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler with a short randomised slot-ownership sweep.
module tb_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ready;
  logic [3:0] fu_busy_ext;
  logic       issue_hold;
  logic [3:0] issue;
  logic       cdb_expect;
  logic [1:0] cdb_fu_id;
  logic [7:0] resv_vec;

  int n_chk = 0;
  int n_err = 0;

  issue_scheduler dut (
    .clk(clk), .rst(rst), .ready(ready), .fu_busy_ext(fu_busy_ext),
    .issue_hold(issue_hold), .issue(issue), .cdb_expect(cdb_expect),
    .cdb_fu_id(cdb_fu_id), .resv_vec(resv_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, check combinational grant and CDB state, advance.
  task automatic cycle(input logic [3:0] rdy, input logic [3:0] bz, input logic hold,
                       input logic [3:0] e_issue, input logic e_cdb, input logic [1:0] e_id);
    ready = rdy; fu_busy_ext = bz; issue_hold = hold;
    #1;
    check("issue", issue, e_issue);
    check("cdb_expect", cdb_expect, e_cdb);
    check("cdb_fu_id", cdb_fu_id, e_id);
    @(posedge clk); #1;
  endtask

  int         lat [4] = '{1, 3, 6, 1};
  logic       sb_v [16];
  logic [1:0] sb_id [16];
  int         last_div;

  initial begin
    rst = 1'b1; ready = 4'b1001; fu_busy_ext = '0; issue_hold = 1'b0;
    #12;
    check("rst_issue", issue, 4'b0000);
    check("rst_cdb", cdb_expect, 1'b0);
    check("rst_id", cdb_fu_id, 2'd0);
    check("rst_resv", resv_vec, 8'h00);
    rst = 1'b0;

    // Build pending reservations, then reset mid-run
    cycle(4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0);
    cycle(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);
    check("resv_pre_rst", resv_vec, 8'b0001_0100);
    rst = 1'b1; ready = 4'b1001;
    #1;
    check("midrst_resv", resv_vec, 8'h00);
    check("midrst_issue", issue, 4'b0000);
    check("midrst_cdb", cdb_expect, 1'b0);
    rst = 1'b0;

    // Round-robin between the two L=1 units
    cycle(4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0);
    cycle(4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd0);
    cycle(4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd3);
    cycle(4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd0);
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3);
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);

    // Latency priority and slot conflict
    cycle(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    cycle(4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0);
    cycle(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd1);
    cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0);

    // Non-pipelined divider, external busy delays the third grant
    for (int o = 0; o < 20; o++) begin
      logic ec;
      ec = (o == 6 || o == 12 || o == 19);
      cycle((o < 14) ? 4'b0100 : 4'b0000, (o == 12) ? 4'b0100 : 4'b0000, 1'b0,
            (o == 0 || o == 6 || o == 13) ? 4'b0100 : 4'b0000, ec, ec ? 2'd2 : 2'd0);
    end

    // Hold: no grants, reservations keep maturing
    cycle(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);
    cycle(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    cycle(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
    cycle(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
    cycle(4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0);
    cycle(4'b1111, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0);
    for (int o = 0; o < 8; o++)
      cycle(4'b0000, 4'b0000, 1'b0, 4'b0000, (o == 2 || o == 4),
            (o == 2) ? 2'd1 : ((o == 4) ? 2'd2 : 2'd0));

    // Random sweep: one grant max, legal grants, every grant returns at t+L
    for (int s = 0; s < 16; s++) begin sb_v[s] = 1'b0; sb_id[s] = '0; end
    last_div = -100;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      ready       = 4'($urandom);
      fu_busy_ext = 4'($urandom & $urandom);
      issue_hold  = ($urandom_range(0, 7) == 0);
      #1;
      check("onehot0", 32'($onehot0(issue)), 1);
      check("legal", |(issue & (~ready | fu_busy_ext | {4{issue_hold}})), 1'b0);
      check("rand_cdb", cdb_expect, sb_v[cyc % 16]);
      check("rand_id", cdb_fu_id, sb_v[cyc % 16] ? sb_id[cyc % 16] : 2'd0);
      sb_v[cyc % 16] = 1'b0;
      for (int g = 0; g < 4; g++) begin
        if (issue[g]) begin
          int sl;
          sl = (cyc + lat[g]) % 16;
          check("slot_free", sb_v[sl], 1'b0);
          sb_v[sl]  = 1'b1;
          sb_id[sl] = 2'(g);
          if (g == 2) begin
            check("div_spacing", (cyc - last_div) >= 6, 1'b1);
            last_div = cyc;
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
